// File: rtl/led_panel_scan_master.sv
// Scan master for a multiplexed HUB-style LED panel: shifts one row per bitplane,
// latches it, then lights it for a binary-weighted on-time (BCM) before moving on.
module led_panel_scan_master #(
  parameter int DISPLAY_ROWS_LINES = 4,
  parameter int DISPLAY_COLS_LINES = 6,
  parameter int COLOR_BITS         = 8,
  parameter int ON_BASE            = 4
) (
  input  logic                                       CLK_LED_MST,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic                                       swap_req,
  output logic                                       swap_ack,
  output logic                                       frame_start,
  output logic [DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES-1:0] memAddrMst,
  output logic [2:0]                                 bitplaneMst,
  output logic                                       backbufferMst,
  output logic [DISPLAY_ROWS_LINES-1:0]              ADDR_MST,
  output logic                                       SHIFT_CLK_MST,
  output logic                                       LATCH_MST,
  output logic                                       BLANK_MST
);

  localparam int R = DISPLAY_ROWS_LINES;
  localparam int C = DISPLAY_COLS_LINES;
  localparam logic [R-1:0]  ROW_LAST = '1;
  localparam logic [C-1:0]  COL_LAST = '1;
  localparam logic [C-1:0]  COL_ZERO = '0;
  localparam logic [2:0]    BP_LAST  = 3'(COLOR_BITS - 1);
  localparam logic [15:0]   ON_LSB   = 16'(ON_BASE);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, ON} state_t;

  state_t        state_reg;
  logic [R-1:0]  row_reg;
  logic [C-1:0]  col_reg;
  logic [2:0]    bp_reg;
  logic          phase_reg;
  logic [15:0]   on_cnt_reg;
  logic          pending_reg;

  logic [R-1:0]  row_inc;
  logic [C-1:0]  col_inc;
  logic [2:0]    bp_inc;
  logic [15:0]   on_load;
  logic          last_bp;
  logic          end_of_frame;

  always_comb begin
    row_inc      = row_reg + 1'b1;
    col_inc      = col_reg + 1'b1;
    bp_inc       = bp_reg + 3'd1;
    // Counter is loaded with (on-time - 1) so the ON state lasts exactly ON_BASE<<bp cycles.
    on_load      = (ON_LSB << bp_reg) - 16'd1;
    last_bp      = (bp_reg == BP_LAST);
    end_of_frame = last_bp && (row_reg == ROW_LAST);
  end

  always_ff @(posedge CLK_LED_MST) begin
    if (reset) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      bp_reg        <= '0;
      phase_reg     <= 1'b0;
      on_cnt_reg    <= '0;
      pending_reg   <= 1'b0;
      swap_ack      <= 1'b0;
      frame_start   <= 1'b0;
      memAddrMst    <= '0;
      bitplaneMst   <= '0;
      backbufferMst <= 1'b0;
      ADDR_MST      <= '0;
      SHIFT_CLK_MST <= 1'b0;
      LATCH_MST     <= 1'b0;
      BLANK_MST     <= 1'b1;
    end else begin
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      pending_reg <= pending_reg | swap_req;

      case (state_reg)
        IDLE: begin
          BLANK_MST     <= 1'b1;
          SHIFT_CLK_MST <= 1'b0;
          LATCH_MST     <= 1'b0;
          if (enable) begin
            state_reg   <= SHIFT;
            row_reg     <= '0;
            col_reg     <= '0;
            bp_reg      <= '0;
            phase_reg   <= 1'b0;
            memAddrMst  <= '0;
            bitplaneMst <= '0;
            frame_start <= 1'b1;
          end
        end

        SHIFT: begin
          if (!phase_reg) begin
            phase_reg     <= 1'b1;
            SHIFT_CLK_MST <= 1'b1;
          end else begin
            phase_reg     <= 1'b0;
            SHIFT_CLK_MST <= 1'b0;
            if (col_reg == COL_LAST) begin
              state_reg <= BLANK;
            end else begin
              col_reg    <= col_inc;
              memAddrMst <= {row_reg, col_inc};
            end
          end
        end

        BLANK: begin
          state_reg <= LATCH;
          LATCH_MST <= 1'b1;
          ADDR_MST  <= row_reg;
        end

        LATCH: begin
          state_reg  <= ON;
          LATCH_MST  <= 1'b0;
          BLANK_MST  <= 1'b0;
          on_cnt_reg <= on_load;
        end

        ON: begin
          if (on_cnt_reg != 16'd0) begin
            on_cnt_reg <= on_cnt_reg - 16'd1;
          end else begin
            BLANK_MST <= 1'b1;
            col_reg   <= '0;
            phase_reg <= 1'b0;
            state_reg <= SHIFT;
            if (!last_bp) begin
              bp_reg      <= bp_inc;
              bitplaneMst <= bp_inc;
              memAddrMst  <= {row_reg, COL_ZERO};
            end else begin
              bp_reg      <= '0;
              bitplaneMst <= '0;
              row_reg     <= row_inc;
              memAddrMst  <= {row_inc, COL_ZERO};
              if (end_of_frame) begin
                // A request in this very cycle is honoured along with any pending one.
                if (pending_reg || swap_req) begin
                  backbufferMst <= ~backbufferMst;
                  swap_ack      <= 1'b1;
                  pending_reg   <= 1'b0;
                end
                if (enable) begin
                  frame_start <= 1'b1;
                end else begin
                  state_reg <= IDLE;
                end
              end
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          BLANK_MST <= 1'b1;
        end
      endcase
    end
  end

endmodule
